// File: rtl/regfile_write_bank.sv
// rtl/regfile_write_bank.sv - write side of the 32 x WIDTH register file with hardwired zero register
module regfile_write_bank #(
    parameter int WIDTH    = 64,
    parameter int ZERO_REG = 31
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             RegWrite,
    input  logic [4:0]       WriteRegister,
    input  logic [WIDTH-1:0] WriteData,
    output logic [WIDTH-1:0] regs [0:31]
);

    logic [1:0]  dec_top;
    logic [3:0]  dec_mid [0:1];
    logic [31:0] dec_out;
    logic [31:0] en;

    function automatic logic [3:0] dec2to4(input logic enable, input logic [1:0] sel);
        logic [3:0] y;
        y = 4'b0000;
        y[sel] = enable;
        return y;
    endfunction

    // 1:2 on bit 4, then each half is a 4:16 built from two 2:4 levels
    always_comb begin
        dec_top = {WriteRegister[4], ~WriteRegister[4]};
        dec_out = '0;
        for (int h = 0; h < 2; h++) begin
            dec_mid[h] = dec2to4(dec_top[h], WriteRegister[3:2]);
            for (int m = 0; m < 4; m++) begin
                dec_out[h*16 + m*4 +: 4] = dec2to4(dec_mid[h][m], WriteRegister[1:0]);
            end
        end
        en = dec_out & {32{RegWrite}};
        en[ZERO_REG] = 1'b0;
    end

    for (genvar i = 0; i < 32; i++) begin : g_reg
        logic [WIDTH-1:0] reg_q;
        logic [WIDTH-1:0] reg_d;

        // The zero register never enables and its hold path is replaced by a constant 0
        if (i == ZERO_REG) begin : g_zero
            assign reg_d = en[i] ? WriteData : '0;
        end else begin : g_rw
            assign reg_d = en[i] ? WriteData : reg_q;
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                reg_q <= '0;
            end else begin
                reg_q <= reg_d;
            end
        end

        assign regs[i] = reg_q;
    end

endmodule

// File: tb/tb_regfile_write_bank.sv
// tb/tb_regfile_write_bank.sv - directed vector bench for regfile_write_bank
`timescale 1ps/1ps
module tb_regfile_write_bank;

    localparam int WIDTH = 64;

    logic             clk;
    logic             reset;
    logic             RegWrite;
    logic [4:0]       WriteRegister;
    logic [WIDTH-1:0] WriteData;
    logic [WIDTH-1:0] regs [0:31];

    int errors = 0;
    int checks = 0;
    logic [WIDTH-1:0] model [0:31];

    typedef struct {
        logic             rst;
        logic             we;
        logic [4:0]       addr;
        logic [WIDTH-1:0] data;
        logic [4:0]       chk;
        logic [WIDTH-1:0] exp;
    } vec_t;

    vec_t vecs[$];

    regfile_write_bank #(.WIDTH(WIDTH), .ZERO_REG(31)) dut (
        .clk           (clk),
        .reset         (reset),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .regs          (regs)
    );

    initial begin
        clk = 1'b0;
        forever #500 clk = ~clk;
    end

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 32; i++) begin
            check($sformatf("%s.x%0d", tag, i), regs[i], model[i]);
        end
    endtask

    task automatic add(input logic rst, input logic we, input logic [4:0] addr,
                       input logic [WIDTH-1:0] data, input logic [4:0] chk, input logic [WIDTH-1:0] exp);
        vec_t v;
        v.rst = rst; v.we = we; v.addr = addr; v.data = data; v.chk = chk; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic apply(input vec_t v, input int n);
        @(negedge clk);
        reset = v.rst;
        RegWrite = v.we;
        WriteRegister = v.addr;
        WriteData = v.data;
        #1;
        if (v.rst) begin
            for (int i = 0; i < 32; i++) model[i] = '0;
            check_all($sformatf("v%0d.pre_reset", n));
        end
        check($sformatf("v%0d.pre_edge_old", n), regs[v.chk], model[v.chk]);
        @(posedge clk);
        #1;
        if (!v.rst && v.we && v.addr != 5'd31) model[v.addr] = v.data;
        check($sformatf("v%0d.target", n), regs[v.chk], v.exp);
        check_all($sformatf("v%0d.all", n));
    endtask

    initial begin
        logic [WIDTH-1:0] pat;
        for (int i = 0; i < 32; i++) model[i] = '0;

        reset = 1'b1;
        RegWrite = 1'b0;
        WriteRegister = 5'd0;
        WriteData = '0;
        #1;
        check_all("reset_state");

        add(1'b1, 1'b0, 5'd0, 64'd0, 5'd0, 64'd0);
        for (int i = 0; i < 31; i++) begin
            pat = 64'(i) * 64'h0101_0101_0101_0101;
            add(1'b0, 1'b1, 5'(i), pat, 5'(i), pat);
        end
        add(1'b0, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 64'd0);
        add(1'b0, 1'b1, 5'd5, 64'd123569, 5'd5, 64'd123569);
        for (int k = 0; k < 3; k++) begin
            add(1'b0, 1'b0, 5'd5, 64'hDEAD_BEEF_0000_0001, 5'd5, 64'd123569);
        end
        add(1'b0, 1'b1, 5'd7, 64'd5000, 5'd7, 64'd5000);
        add(1'b0, 1'b1, 5'd7, 64'd8745985632, 5'd7, 64'd8745985632);
        add(1'b1, 1'b1, 5'd3, 64'd14, 5'd3, 64'd0);
        add(1'b0, 1'b1, 5'd3, 64'd14, 5'd3, 64'd14);

        for (int n = 0; n < vecs.size(); n++) begin
            apply(vecs[n], n);
        end

        // Address and data move mid-cycle; only the values present at the edge land
        @(negedge clk);
        RegWrite = 1'b1;
        WriteRegister = 5'd10;
        WriteData = 64'hAAAA_0000_AAAA_0000;
        #200;
        WriteRegister = 5'd11;
        WriteData = 64'h0000_BBBB_0000_BBBB;
        @(posedge clk);
        #1;
        model[11] = 64'h0000_BBBB_0000_BBBB;
        check("midchange.x11", regs[11], 64'h0000_BBBB_0000_BBBB);
        check("midchange.x10", regs[10], 64'd0);
        check_all("midchange.all");

        // Reset pulse entirely between edges clears asynchronously; no write follows
        @(negedge clk);
        RegWrite = 1'b0;
        reset = 1'b1;
        #100;
        for (int i = 0; i < 32; i++) model[i] = '0;
        check("pulse.x11", regs[11], 64'd0);
        check_all("pulse.during");
        reset = 1'b0;
        #100;
        check_all("pulse.released");
        @(posedge clk);
        #1;
        check_all("pulse.after_edge");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
